// File: rtl/alu_operand_stage_pkg.sv
// Shared select codes and skid-buffer occupancy type for the ALU operand stage.
package alu_operand_stage_pkg;

  // Operand-1 bus slot assignments (6502 datapath names).
  typedef enum logic [3:0] {
    SRC1_A   = 4'd0,
    SRC1_BAL = 4'd1,
    SRC1_BAH = 4'd2,
    SRC1_ADL = 4'd3,
    SRC1_PCL = 4'd4,
    SRC1_PCH = 4'd5,
    SRC1_DC  = 4'd6
  } src1_sel_e;

  // Operand-2 bus slot assignments.
  typedef enum logic [3:0] {
    SRC2_IMM         = 4'd0,
    SRC2_ADV         = 4'd1,
    SRC2_X           = 4'd2,
    SRC2_BAV         = 4'd3,
    SRC2_Y           = 4'd4,
    SRC2_OFFSET      = 4'd5,
    SRC2_SP          = 4'd6,
    SRC2_TEMP_STATUS = 4'd7
  } src2_sel_e;

  // Forwarded-result code for the default eight-slot configuration.
  typedef enum logic [3:0] {
    SRC_FWD = 4'd8
  } src_fwd_e;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Capture/output handshake and operand source bundle for the ALU operand stage.
interface alu_operand_stage_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned N1    = 8,
  parameter int unsigned N2    = 8,
  parameter int unsigned SEL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  src1_sel;
  logic [SEL_W-1:0]  src2_sel;
  logic [N1*W-1:0]   src1_bus;
  logic [N2*W-1:0]   src2_bus;
  logic              inv2;
  logic              cin;
  logic [W-1:0]      alu_result;
  logic              alu_result_valid;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      in1;
  logic [W-1:0]      in2;
  logic              out_cin;

  // Upstream/ALU side: drives requests, sources and consumption.
  modport master (
    output in_valid, src1_sel, src2_sel, src1_bus, src2_bus, inv2, cin,
           alu_result, alu_result_valid, out_ready,
    input  in_ready, out_valid, in1, in2, out_cin
  );

  // Operand stage side.
  modport slave (
    input  in_valid, src1_sel, src2_sel, src1_bus, src2_bus, inv2, cin,
           alu_result, alu_result_valid, out_ready,
    output in_ready, out_valid, in1, in2, out_cin
  );
endinterface

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer; head entry is held in the output register.
module alu_skid_buf
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned DW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  occ_e          state_q, state_d;
  logic [DW-1:0] head_q, skid_q;
  logic          push, pop;
  logic          load_head_in, load_head_skid, load_skid;

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy update from capture/transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_FULL;
        else if (!push && pop) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Handshake outputs and data-register load enables, all from registered occupancy.
  always_comb begin
    in_ready       = !rst && (state_q != OCC_FULL);
    out_valid      = (state_q != OCC_EMPTY);
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    // A capture goes straight to the head when the head is free or leaving this cycle.
    load_head_in   = push && ((state_q == OCC_EMPTY) || pop);
    load_skid      = push && (state_q == OCC_ONE) && !pop;
    load_head_skid = pop && (state_q == OCC_FULL);
  end

  // Head and skid payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_in)        head_q <= in_data;
      else if (load_head_skid) head_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign out_data = head_q;

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand selector: source/forward mux, operand-2 inversion and skid-buffered output.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N1    = 8,
  parameter int unsigned N2    = 8,
  parameter int unsigned SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_operand_stage_if.slave io
);

  logic [W-1:0]   fwd_q;
  logic [W-1:0]   fwd_val;
  logic [W-1:0]   op1, op2_sel, op2;
  logic [2*W:0]   cap_payload;
  logic [2*W:0]   out_payload;

  // Last valid ALU result, tracked regardless of the handshake.
  always_ff @(posedge clk) begin
    if (rst)                      fwd_q <= '0;
    else if (io.alu_result_valid) fwd_q <= io.alu_result;
  end

  // Same-cycle result bypasses the forward register.
  always_comb begin
    fwd_val = io.alu_result_valid ? io.alu_result : fwd_q;
  end

  // Operand 1: bus slot, forwarded value, or zero for out-of-range codes.
  always_comb begin
    op1 = '0;
    for (int unsigned k = 0; k < N1; k++) begin
      if (32'(io.src1_sel) == k) op1 = io.src1_bus[k*W +: W];
    end
    if (32'(io.src1_sel) == N1) op1 = fwd_val;
  end

  // Operand 2: same selection rule, then optional inversion.
  always_comb begin
    op2_sel = '0;
    for (int unsigned k = 0; k < N2; k++) begin
      if (32'(io.src2_sel) == k) op2_sel = io.src2_bus[k*W +: W];
    end
    if (32'(io.src2_sel) == N2) op2_sel = fwd_val;
    op2 = io.inv2 ? ~op2_sel : op2_sel;
  end

  assign cap_payload = {io.cin, op2, op1};

  alu_skid_buf #(
    .DW (2*W + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (io.in_valid),
    .in_ready  (io.in_ready),
    .in_data   (cap_payload),
    .out_valid (io.out_valid),
    .out_ready (io.out_ready),
    .out_data  (out_payload)
  );

  assign io.in1     = out_payload[W-1:0];
  assign io.in2     = out_payload[2*W-1:W];
  assign io.out_cin = out_payload[2*W];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (8-bit and 16-bit instances).
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.W(8),  .N1(8), .N2(8), .SEL_W(4)) a_if ();
  alu_operand_stage_if #(.W(16), .N1(4), .N2(4), .SEL_W(4)) b_if ();

  alu_operand_stage #(.W(8),  .N1(8), .N2(8), .SEL_W(4)) dut_a (.clk(clk), .rst(rst), .io(a_if));
  alu_operand_stage #(.W(16), .N1(4), .N2(4), .SEL_W(4)) dut_b (.clk(clk), .rst(rst), .io(b_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Set selects and place values in the selected slots (when in range).
  task automatic load_a(input logic [3:0] s1, input logic [7:0] v1,
                        input logic [3:0] s2, input logic [7:0] v2);
    a_if.src1_sel = s1;
    a_if.src2_sel = s2;
    if (s1 < 4'd8) a_if.src1_bus[int'(s1)*8 +: 8] = v1;
    if (s2 < 4'd8) a_if.src2_bus[int'(s2)*8 +: 8] = v2;
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.src1_sel = '0; a_if.src2_sel = '0;
    a_if.src1_bus = '0;   a_if.src2_bus = '0; a_if.inv2 = 1'b0; a_if.cin = 1'b0;
    a_if.alu_result = '0; a_if.alu_result_valid = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.src1_sel = '0; b_if.src2_sel = '0;
    b_if.src1_bus = '0;   b_if.src2_bus = '0; b_if.inv2 = 1'b0; b_if.cin = 1'b0;
    b_if.alu_result = '0; b_if.alu_result_valid = 1'b0; b_if.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_in_ready", a_if.in_ready, 0);
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_in1", a_if.in1, 0);
    check("rst_in2", a_if.in2, 0);
    check("rst_cin", a_if.out_cin, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", a_if.in_ready, 1);

    // Single capture, 1-cycle latency
    load_a(SRC1_A, 8'h12, SRC2_ADV, 8'h34);
    a_if.in_valid = 1'b1;
    tick();
    check("t1_valid", a_if.out_valid, 1);
    check("t1_in1", a_if.in1, 32'h12);
    check("t1_in2", a_if.in2, 32'h34);
    a_if.in_valid = 1'b0;
    tick();
    check("t1_drain", a_if.out_valid, 0);

    // Three back-to-back captures under stall
    a_if.out_ready = 1'b0;
    load_a(4'd0, 8'h11, 4'd0, 8'h22); a_if.in_valid = 1'b1;
    tick();
    check("t2_ready1", a_if.in_ready, 1);
    load_a(4'd0, 8'h33, 4'd0, 8'h44);
    tick();
    check("t2_ready_full", a_if.in_ready, 0);
    check("t2_head_in1", a_if.in1, 32'h11);
    load_a(4'd0, 8'h55, 4'd0, 8'h66);
    tick();
    check("t2_stall_valid", a_if.out_valid, 1);
    check("t2_stall_in1", a_if.in1, 32'h11);
    check("t2_stall_in2", a_if.in2, 32'h22);
    check("t2_stall_ready", a_if.in_ready, 0);
    a_if.out_ready = 1'b1;
    tick();
    check("t2_p2_in1", a_if.in1, 32'h33);
    check("t2_p2_in2", a_if.in2, 32'h44);
    check("t2_p2_ready", a_if.in_ready, 1);
    tick();
    check("t2_p3_in1", a_if.in1, 32'h55);
    check("t2_p3_in2", a_if.in2, 32'h66);
    check("t2_p3_valid", a_if.out_valid, 1);
    a_if.in_valid = 1'b0;
    tick();
    check("t2_empty", a_if.out_valid, 0);

    // Forwarding: same-cycle bypass, then from the forward register
    load_a(SRC_FWD, 8'h00, 4'd0, 8'h5A);
    a_if.alu_result = 8'hA5; a_if.alu_result_valid = 1'b1; a_if.in_valid = 1'b1;
    tick();
    check("t3_bypass", a_if.in1, 32'hA5);
    check("t3_bypass_in2", a_if.in2, 32'h5A);
    a_if.alu_result = 8'h3C; a_if.alu_result_valid = 1'b0;
    tick();
    check("t3_fwd_q", a_if.in1, 32'hA5);
    a_if.alu_result = 8'hC3; a_if.alu_result_valid = 1'b1;
    tick();
    check("t3_bypass_prio", a_if.in1, 32'hC3);
    a_if.alu_result_valid = 1'b0;

    // Inversion, carry, out-of-range and top-slot selects
    load_a(4'd15, 8'h00, SRC2_X, 8'h0F);
    a_if.inv2 = 1'b1; a_if.cin = 1'b1;
    tick();
    check("t4_inv2", a_if.in2, 32'hF0);
    check("t4_cin", a_if.out_cin, 1);
    check("t4_oor1", a_if.in1, 32'h00);
    load_a(4'd7, 8'h77, 4'd9, 8'h00);
    a_if.cin = 1'b0;
    tick();
    check("t4_slot7", a_if.in1, 32'h77);
    check("t4_oor2_inv", a_if.in2, 32'hFF);
    check("t4_cin0", a_if.out_cin, 0);
    a_if.inv2 = 1'b0;
    a_if.in_valid = 1'b0;
    tick();

    // Reset with a full buffer
    a_if.out_ready = 1'b0;
    load_a(4'd0, 8'hAA, 4'd0, 8'hBB); a_if.in_valid = 1'b1;
    tick();
    load_a(4'd0, 8'hCC, 4'd0, 8'hDD);
    tick();
    check("t5_full", a_if.in_ready, 0);
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_rst_valid", a_if.out_valid, 0);
    check("t5_rst_in1", a_if.in1, 0);
    check("t5_rst_in2", a_if.in2, 0);
    check("t5_rst_ready", a_if.in_ready, 0);
    rst = 1'b0;
    a_if.out_ready = 1'b1;
    tick();
    check("t5_ready_after", a_if.in_ready, 1);
    check("t5_no_stale0", a_if.out_valid, 0);
    tick();
    check("t5_no_stale1", a_if.out_valid, 0);
    load_a(SRC_FWD, 8'h00, 4'd0, 8'h01); a_if.in_valid = 1'b1;
    tick();
    check("t5_fwd_cleared", a_if.in1, 32'h00);
    a_if.in_valid = 1'b0;

    // 16-bit, four-slot instance
    b_if.src1_bus[3*16 +: 16] = 16'hBEEF;
    b_if.src2_bus[0 +: 16]    = 16'h1234;
    b_if.src1_sel = 4'd3; b_if.src2_sel = 4'd0; b_if.in_valid = 1'b1;
    tick();
    check("t6_slot3", b_if.in1, 32'hBEEF);
    check("t6_in2", b_if.in2, 32'h1234);
    b_if.src1_sel = 4'd4; b_if.alu_result = 16'hCAFE; b_if.alu_result_valid = 1'b1;
    tick();
    check("t6_fwd", b_if.in1, 32'hCAFE);
    b_if.in_valid = 1'b0; b_if.alu_result_valid = 1'b0;
    tick();
    check("t6_drain", b_if.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
